kernel_link_stats: RTL and testbench
====================================

Name: kernel_link_stats

Overview:
Parametrised successor to the per-link debug counters of the kernel top. Counts send and receive events on NUM_CH SFP/GTP channels and measures per-window rates. Tracks outstanding (sent minus received) frames per channel, with a sticky lag flag. All values are captured into a coherent snapshot and read through a 1-cycle-latency register port. It sits beside the kernel send/receive pair in the ap_clk domain.

Parameters:
NUM_CH, 2, number of monitored channels (1..16)
CNT_W, 32, width of cumulative counters and outstanding value
WIN_W, 24, width of window length and per-window rate counters
ADDR_W, 6, read address width; must satisfy 2^ADDR_W >= NUM_CH*4

Ports:
ap_clk  in  1  single clock for all logic
ap_rst_n  in  1  synchronous, active-low reset
ev_tx  in  NUM_CH  per-channel send event, one count per high cycle (e.g. sfp_wr_en)
ev_rx  in  NUM_CH  per-channel receive event, one count per high cycle (e.g. send_start)
clr  in  1  pulse: zero counters, rates, window and sticky flags
snap  in  1  pulse: copy cumulative counters into shadow registers
win_len  in  WIN_W  window length in ap_clk cycles; 0 disables windowing
lag_thr  in  CNT_W  outstanding threshold for lag flag
rd_en  in  1  read strobe
rd_addr  in  ADDR_W  read address
rd_data  out  CNT_W  read data, valid with rd_valid
rd_valid  out  1  high exactly 1 cycle after each rd_en
lag_err  out  NUM_CH  sticky per-channel lag flag
win_tick  out  1  1-cycle pulse at each window close

Behaviour:
- Reset (ap_rst_n low at a clock edge): all counters, shadows, rates and the window counter go to 0. rd_data=0, rd_valid=0, lag_err=0, win_tick=0. Reset mid-operation discards everything; no partial state survives.
- Cumulative counters: tx_cnt[c] increments when ev_tx[c]=1; rx_cnt[c] likewise. They wrap modulo 2^CNT_W.
- Outstanding: out[c] = tx_cnt[c] - rx_cnt[c], modulo 2^CNT_W, unsigned.
- lag_err[c] is set on the cycle after out[c] > lag_thr is true. It stays set until clr or reset.
- Window: wcnt counts 0..win_len-1.
  - On wcnt == win_len-1: win_tick pulses the next cycle, and wcnt returns to 0.
  - At the same edge, tx_rate[c]/rx_rate[c] load the window event count, including any event on the terminal cycle. The window accumulators restart at 0.
  - Window accumulators saturate at 2^WIN_W-1.
  - win_len=0: wcnt held at 0, no win_tick, rates hold their last values.
  - win_len changed mid-window: the new value is compared immediately. If wcnt >= new win_len-1, the window closes at the next edge.
- Snapshot: on snap, shadow_tx[c] <= tx_cnt[c] and shadow_rx[c] <= rx_cnt[c] for all channels at the same edge. The captured value excludes events on the snap cycle.
- clr: all counters, accumulators, rates, wcnt and lag_err go to 0 at the edge. Events on the clr cycle are dropped. Shadows are not cleared.
- clr and snap in the same cycle: the shadows capture the pre-clear values, then the counters go to 0.
- Read map, with c = rd_addr[ADDR_W-1:2] and sub = rd_addr[1:0]:
  - sub 0: shadow_tx[c]
  - sub 1: shadow_rx[c]
  - sub 2: tx_rate[c], zero-extended
  - sub 3: rx_rate[c], zero-extended
  - c >= NUM_CH returns 0.
- rd_data is registered and updates only on rd_en; otherwise it holds. A read in the snap cycle returns the old shadow.
- Back-to-back rd_en is allowed, one result per cycle.

Optional Feature:
KERNEL_LINK_STATS_SAT_EN:
- Defined: tx_cnt/rx_cnt saturate at 2^CNT_W-1 instead of wrapping. Reads of sub 0/1 for a saturated channel return all-ones.
- Undefined: counters wrap modulo 2^CNT_W, and out[c] wrap arithmetic remains correct across the wrap.

Test Plan:
- Reset, then 10 ev_tx[0] and 4 ev_rx[0] pulses, then snap, then read addr 0 and 1 -> rd_valid 1 cycle after each rd_en; rd_data 10 then 4.
- win_len=100; ev_tx[1] held high for 37 consecutive cycles inside one window -> win_tick every 100 cycles; read addr 6 returns 37; the next idle window returns 0.
- lag_thr=5, 6 ev_tx[0] and 0 ev_rx[0] -> lag_err[0]=1 one cycle after the 6th event. It stays 1 after rx catches up; clr clears it.
- clr and snap in the same cycle after 20 tx events on ch0 -> addr 0 reads 20; the following snap with no events reads 0. An ev_tx on the clr cycle is not counted.
- CNT_W=8, 260 ev_tx[0] pulses -> addr 0 reads 4 without the macro, 255 with KERNEL_LINK_STATS_SAT_EN.
- ap_rst_n low mid-window with nonzero counters -> all reads return 0, lag_err=0, and the next win_tick arrives win_len cycles after reset release.

Source files
------------

// File: rtl/kernel_link_stats.sv
// Per-channel send/receive counters, windowed rates, outstanding-frame lag flags and a snapshot read port.
// Optional define KERNEL_LINK_STATS_SAT_EN makes the cumulative counters saturate instead of wrapping.
module kernel_link_stats #(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 32,
   parameter int WIN_W  = 24,
   parameter int ADDR_W = 6
) (
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   input  logic [NUM_CH-1:0] ev_tx,
   input  logic [NUM_CH-1:0] ev_rx,
   input  logic              clr,
   input  logic              snap,
   input  logic [WIN_W-1:0]  win_len,
   input  logic [CNT_W-1:0]  lag_thr,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [CNT_W-1:0]  rd_data,
   output logic              rd_valid,
   output logic [NUM_CH-1:0] lag_err,
   output logic              win_tick
);

   localparam int SLOT_W   = ADDR_W - 2;
   localparam int NUM_SLOT = 1 << SLOT_W;

   logic [WIN_W-1:0] wcnt_reg;
   logic [WIN_W-1:0] wcnt_next;
   logic             win_tick_reg;
   logic             win_close;
   logic             win_off;

   logic [CNT_W-1:0] shadow_tx_w [NUM_SLOT];
   logic [CNT_W-1:0] shadow_rx_w [NUM_SLOT];
   logic [WIN_W-1:0] tx_rate_w   [NUM_SLOT];
   logic [WIN_W-1:0] rx_rate_w   [NUM_SLOT];

   logic [CNT_W-1:0]  rd_data_reg;
   logic [CNT_W-1:0]  rd_word;
   logic              rd_valid_reg;
   logic [SLOT_W-1:0] rd_ch;

   // A shrunken win_len takes effect at once: any wcnt at or past the new end closes the window.
   assign win_off   = (win_len == '0);
   assign win_close = !win_off && (wcnt_reg >= (win_len - WIN_W'(1)));

   always_comb begin
      wcnt_next = wcnt_reg + WIN_W'(1);
      if (clr || win_off || win_close) begin
         wcnt_next = '0;
      end
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         wcnt_reg     <= '0;
         win_tick_reg <= 1'b0;
      end else begin
         wcnt_reg     <= wcnt_next;
         win_tick_reg <= win_close && !clr;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [CNT_W-1:0] tx_cnt_reg, rx_cnt_reg;
         logic [CNT_W-1:0] tx_cnt_next, rx_cnt_next;
         logic [CNT_W-1:0] shadow_tx_reg, shadow_rx_reg;
         logic [CNT_W-1:0] out_val;
         logic [WIN_W-1:0] tx_acc_reg, rx_acc_reg;
         logic [WIN_W-1:0] tx_acc_next, rx_acc_next;
         logic [WIN_W-1:0] tx_rate_reg, rx_rate_reg;
         logic             lag_reg;

`ifdef KERNEL_LINK_STATS_SAT_EN
         assign tx_cnt_next = (ev_tx[gi] && (tx_cnt_reg != '1)) ? tx_cnt_reg + CNT_W'(1) : tx_cnt_reg;
         assign rx_cnt_next = (ev_rx[gi] && (rx_cnt_reg != '1)) ? rx_cnt_reg + CNT_W'(1) : rx_cnt_reg;
`else
         assign tx_cnt_next = tx_cnt_reg + CNT_W'(ev_tx[gi]);
         assign rx_cnt_next = rx_cnt_reg + CNT_W'(ev_rx[gi]);
`endif

         // Window accumulators include the current cycle's event so the terminal cycle is counted.
         assign tx_acc_next = (ev_tx[gi] && (tx_acc_reg != '1)) ? tx_acc_reg + WIN_W'(1) : tx_acc_reg;
         assign rx_acc_next = (ev_rx[gi] && (rx_acc_reg != '1)) ? rx_acc_reg + WIN_W'(1) : rx_acc_reg;
         assign out_val     = tx_cnt_reg - rx_cnt_reg;

         always_ff @(posedge ap_clk) begin
            if (!ap_rst_n) begin
               tx_cnt_reg    <= '0;
               rx_cnt_reg    <= '0;
               shadow_tx_reg <= '0;
               shadow_rx_reg <= '0;
               tx_acc_reg    <= '0;
               rx_acc_reg    <= '0;
               tx_rate_reg   <= '0;
               rx_rate_reg   <= '0;
               lag_reg       <= 1'b0;
            end else begin
               if (snap) begin
                  shadow_tx_reg <= tx_cnt_reg;
                  shadow_rx_reg <= rx_cnt_reg;
               end
               if (clr) begin
                  tx_cnt_reg  <= '0;
                  rx_cnt_reg  <= '0;
                  tx_acc_reg  <= '0;
                  rx_acc_reg  <= '0;
                  tx_rate_reg <= '0;
                  rx_rate_reg <= '0;
                  lag_reg     <= 1'b0;
               end else begin
                  tx_cnt_reg <= tx_cnt_next;
                  rx_cnt_reg <= rx_cnt_next;
                  lag_reg    <= lag_reg || (out_val > lag_thr);
                  if (win_close) begin
                     tx_rate_reg <= tx_acc_next;
                     rx_rate_reg <= rx_acc_next;
                     tx_acc_reg  <= '0;
                     rx_acc_reg  <= '0;
                  end else if (win_off) begin
                     // Hold accumulators empty so re-enabling starts a clean window.
                     tx_acc_reg <= '0;
                     rx_acc_reg <= '0;
                  end else begin
                     tx_acc_reg <= tx_acc_next;
                     rx_acc_reg <= rx_acc_next;
                  end
               end
            end
         end

         assign shadow_tx_w[gi] = shadow_tx_reg;
         assign shadow_rx_w[gi] = shadow_rx_reg;
         assign tx_rate_w[gi]   = tx_rate_reg;
         assign rx_rate_w[gi]   = rx_rate_reg;
         assign lag_err[gi]     = lag_reg;
      end

      // Unpopulated address slots read as zero.
      for (gi = NUM_CH; gi < NUM_SLOT; gi++) begin : g_pad
         assign shadow_tx_w[gi] = '0;
         assign shadow_rx_w[gi] = '0;
         assign tx_rate_w[gi]   = '0;
         assign rx_rate_w[gi]   = '0;
      end
   endgenerate

   assign rd_ch = rd_addr[ADDR_W-1:2];

   always_comb begin
      rd_word = '0;
      case (rd_addr[1:0])
         2'd0: rd_word = shadow_tx_w[rd_ch];
         2'd1: rd_word = shadow_rx_w[rd_ch];
         2'd2: rd_word = CNT_W'(tx_rate_w[rd_ch]);
         2'd3: rd_word = CNT_W'(rx_rate_w[rd_ch]);
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         rd_data_reg  <= '0;
         rd_valid_reg <= 1'b0;
      end else begin
         rd_valid_reg <= rd_en;
         if (rd_en) begin
            rd_data_reg <= rd_word;
         end
      end
   end

   assign rd_data  = rd_data_reg;
   assign rd_valid = rd_valid_reg;
   assign win_tick = win_tick_reg;

endmodule

// File: tb/tb_kernel_link_stats.sv
// Bench for kernel_link_stats: table-driven counter vectors, scoreboarded reads, window/lag/clr/reset sequences.
module tb_kernel_link_stats;

   localparam int NUM_CH = 2;
   localparam int CNT_W  = 32;
   localparam int WIN_W  = 24;
   localparam int ADDR_W = 6;

   logic              ap_clk = 1'b0;
   logic              ap_rst_n;
   logic [NUM_CH-1:0] ev_tx, ev_rx;
   logic              clr, snap;
   logic [WIN_W-1:0]  win_len;
   logic [CNT_W-1:0]  lag_thr;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [CNT_W-1:0]  rd_data;
   logic              rd_valid;
   logic [NUM_CH-1:0] lag_err;
   logic              win_tick;

   // Narrow single-channel instance for the wrap/saturation case
   logic [0:0] ev_tx2, ev_rx2, lag_err2;
   logic       clr2, snap2, rd_en2, rd_valid2, win_tick2;
   logic [7:0] win_len2, lag_thr2, rd_data2;
   logic [2:0] rd_addr2;

   always #5 ap_clk = ~ap_clk;

   kernel_link_stats #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .WIN_W(WIN_W), .ADDR_W(ADDR_W)) dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ev_tx(ev_tx), .ev_rx(ev_rx),
      .clr(clr), .snap(snap), .win_len(win_len), .lag_thr(lag_thr),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
      .lag_err(lag_err), .win_tick(win_tick)
   );

   kernel_link_stats #(.NUM_CH(1), .CNT_W(8), .WIN_W(8), .ADDR_W(3)) dut2 (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ev_tx(ev_tx2), .ev_rx(ev_rx2),
      .clr(clr2), .snap(snap2), .win_len(win_len2), .lag_thr(lag_thr2),
      .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2), .rd_valid(rd_valid2),
      .lag_err(lag_err2), .win_tick(win_tick2)
   );

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [CNT_W-1:0]  data;
   } rd_exp_t;

   typedef struct {
      int tx0, rx0, tx1, rx1;
      logic [CNT_W-1:0] e_tx0, e_rx0, e_tx1, e_rx1;
   } vec_t;

   rd_exp_t exp_q[$];
   rd_exp_t exp_q2[$];
   vec_t    vecs[4];
   int      checks = 0;
   int      errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Advance one clock and score any read result the DUTs produced.
   task automatic step();
      logic    en_was, en2_was;
      rd_exp_t e;
      en_was  = rd_en;
      en2_was = rd_en2;
      @(posedge ap_clk);
      #1;
      if (rd_valid || en_was) chk("rd_valid", rd_valid, en_was);
      if (rd_valid) begin
         if (exp_q.size() == 0) chk("rd_unexpected", 1, 0);
         else begin
            e = exp_q.pop_front();
            $display("read addr %0d data %0d expected %0d", e.addr, rd_data, e.data);
            chk($sformatf("rd_data addr %0d", e.addr), rd_data, e.data);
         end
      end
      if (rd_valid2 || en2_was) chk("rd_valid2", rd_valid2, en2_was);
      if (rd_valid2) begin
         if (exp_q2.size() == 0) chk("rd2_unexpected", 1, 0);
         else begin
            e = exp_q2.pop_front();
            $display("read2 addr %0d data %0d expected %0d", e.addr, rd_data2, e.data);
            chk($sformatf("rd2_data addr %0d", e.addr), rd_data2, e.data);
         end
      end
   endtask

   task automatic rd(input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] d);
      rd_exp_t e;
      e.addr = a;
      e.data = d;
      rd_en   = 1'b1;
      rd_addr = a;
      exp_q.push_back(e);
   endtask

   initial begin
      int n;
      int m;
      rd_exp_t e2;

      vecs[0] = '{tx0: 10, rx0: 4, tx1: 0, rx1: 0, e_tx0: 10, e_rx0: 4,  e_tx1: 0,  e_rx1: 0};
      vecs[1] = '{tx0: 3,  rx0: 7, tx1: 5, rx1: 2, e_tx0: 13, e_rx0: 11, e_tx1: 5,  e_rx1: 2};
      vecs[2] = '{tx0: 0,  rx0: 0, tx1: 8, rx1: 9, e_tx0: 13, e_rx0: 11, e_tx1: 13, e_rx1: 11};
      vecs[3] = '{tx0: 1,  rx0: 1, tx1: 1, rx1: 1, e_tx0: 14, e_rx0: 12, e_tx1: 14, e_rx1: 12};

      ap_rst_n = 1'b0; ev_tx = '0; ev_rx = '0; clr = 1'b0; snap = 1'b0;
      win_len = '0; lag_thr = '1; rd_en = 1'b0; rd_addr = '0;
      ev_tx2 = '0; ev_rx2 = '0; clr2 = 1'b0; snap2 = 1'b0; win_len2 = '0;
      lag_thr2 = '1; rd_en2 = 1'b0; rd_addr2 = '0;

      // Reset state
      step(); step();
      chk("reset rd_data", rd_data, 0);
      chk("reset rd_valid", rd_valid, 0);
      chk("reset lag_err", lag_err, 0);
      chk("reset win_tick", win_tick, 0);
      chk("reset rd_data2", rd_data2, 0);
      ap_rst_n = 1'b1;
      step();

      // Table-driven cumulative counter vectors
      for (int i = 0; i < 4; i++) begin
         m = vecs[i].tx0;
         if (vecs[i].rx0 > m) m = vecs[i].rx0;
         if (vecs[i].tx1 > m) m = vecs[i].tx1;
         if (vecs[i].rx1 > m) m = vecs[i].rx1;
         for (int k = 0; k < m; k++) begin
            ev_tx[0] = (k < vecs[i].tx0);
            ev_rx[0] = (k < vecs[i].rx0);
            ev_tx[1] = (k < vecs[i].tx1);
            ev_rx[1] = (k < vecs[i].rx1);
            step();
         end
         ev_tx = '0; ev_rx = '0;
         snap = 1'b1; step(); snap = 1'b0;
         rd(0, vecs[i].e_tx0); step();
         rd(1, vecs[i].e_rx0); step();
         rd(4, vecs[i].e_tx1); step();
         rd(5, vecs[i].e_rx1); step();
         rd_en = 1'b0; step();
      end
      chk("no lag with high thr", lag_err, 0);

      // Out-of-range channel reads return zero
      rd(8, 0); step();
      rd(63, 0); step();
      rd_en = 1'b0; step();

      // Read in the snap cycle returns the old shadow
      ev_tx[0] = 1'b1; step(); step(); ev_tx[0] = 1'b0;
      snap = 1'b1; rd(0, 14); step(); snap = 1'b0;
      rd(0, 16); step();
      rd_en = 1'b0; step();

      // Lag flag: threshold 5, sticky until clr
      clr = 1'b1; step(); clr = 1'b0;
      lag_thr = 5;
      ev_tx[0] = 1'b1;
      repeat (5) step();
      ev_tx[0] = 1'b0;
      repeat (3) step();
      chk("lag at out=thr", lag_err[0], 0);
      ev_tx[0] = 1'b1; step(); ev_tx[0] = 1'b0;
      chk("lag before set cycle", lag_err[0], 0);
      step();
      chk("lag set", lag_err[0], 1);
      chk("lag other channel", lag_err[1], 0);
      ev_rx[0] = 1'b1;
      repeat (6) step();
      ev_rx[0] = 1'b0;
      step();
      chk("lag sticky", lag_err[0], 1);
      clr = 1'b1; step(); clr = 1'b0;
      chk("lag cleared", lag_err[0], 0);

      // clr + snap together, event on clr cycle dropped
      ev_tx[0] = 1'b1;
      repeat (20) step();
      clr = 1'b1; snap = 1'b1; step();
      clr = 1'b0; snap = 1'b0; ev_tx[0] = 1'b0;
      rd(0, 20); step();
      rd_en = 1'b0; step();
      snap = 1'b1; step(); snap = 1'b0;
      rd(0, 0); step();
      rd_en = 1'b0; step();

      // Window rates with win_len = 100
      lag_thr = '1;
      clr = 1'b1; step(); clr = 1'b0;
      win_len = 100;
      n = 0;
      while (!win_tick && n < 300) begin step(); n++; end
      chk("first tick seen", win_tick, 1);
      n = 0;
      ev_tx[1] = 1'b1;
      for (int k = 0; k < 37; k++) begin
         step(); n++;
         if (k == 0) chk("tick pulse width", win_tick, 0);
      end
      ev_tx[1] = 1'b0;
      while (!win_tick && n < 300) begin step(); n++; end
      chk("tick period", n, 100);
      rd(6, 37); step();
      rd(7, 0); step();
      rd(2, 0); step();
      rd_en = 1'b0; step();
      n = 4;
      while (!win_tick && n < 300) begin step(); n++; end
      chk("idle tick period", n, 100);
      rd(6, 0); step();
      rd_en = 1'b0; step();
      n = 2;
      while (n < 50) begin step(); n++; end
      win_len = 20;
      step();
      chk("shrunk window closes", win_tick, 1);
      win_len = '0;
      repeat (5) step();
      chk("disabled window no tick", win_tick, 0);

      // Wrap or saturate on the narrow instance
      ev_tx2 = 1'b1;
      repeat (260) step();
      ev_tx2 = 1'b0;
      step();
      snap2 = 1'b1; step(); snap2 = 1'b0;
      e2.addr = 0;
`ifdef KERNEL_LINK_STATS_SAT_EN
      e2.data = 255;
`else
      e2.data = 4;
`endif
      exp_q2.push_back(e2);
      rd_en2 = 1'b1; rd_addr2 = 0; step();
      rd_en2 = 1'b0; step();

      // Reset mid-window discards everything
      win_len = 10;
      ev_tx[0] = 1'b1;
      repeat (5) step();
      ev_tx[0] = 1'b0;
      snap = 1'b1; step(); snap = 1'b0;
      rd(0, 5); step();
      rd(4, 37); step();
      rd_en = 1'b0; step();
      step(); step();
      ap_rst_n = 1'b0;
      step(); step();
      chk("mid reset rd_data", rd_data, 0);
      chk("mid reset win_tick", win_tick, 0);
      ap_rst_n = 1'b1;
      n = 0;
      while (!win_tick && n < 50) begin step(); n++; end
      chk("tick after reset", n, 10);
      chk("lag after reset", lag_err, 0);
      for (int a = 0; a < 8; a++) begin
         rd(a[ADDR_W-1:0], 0); step();
      end
      rd_en = 1'b0; step(); step();

      chk("scoreboard drained", exp_q.size() + exp_q2.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
